// File: rtl/booth_r4_seq_mul_if.sv
// Operand/result handshake bundle for booth_r4_seq_mul.
//   master: requester/consumer side (drives operands, out_ready)
//   slave : multiplier side (drives in_ready, out_valid, out_product)
// Signals: in_valid/in_ready/in_signed/in_a/in_b (operand channel),
//          out_valid/out_ready/out_product (result channel).
interface booth_r4_seq_mul_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_signed;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/booth_r4_seq_mul.sv
// Multi-cycle radix-4 Booth multiplier, signed or unsigned per operation.
// Sums PP_PER_CYCLE Booth partial products per BUSY cycle into a 2*WIDTH
// accumulator; result is held until the consumer takes it.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - booth_r4_seq_mul_if.slave (operand and result handshakes)
// Optional: define BOOTH_EARLY_TERM_EN to finish as soon as the remaining
//   multiplier bits can only produce zero-valued segments.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// BUSY  | accumulating partial products
// DONE  | product valid, waiting for out_ready
module booth_r4_seq_mul #(
  parameter int WIDTH        = 32,
  parameter int PP_PER_CYCLE = 2
) (
  input logic             clk,
  input logic             rst_n,
  booth_r4_seq_mul_if.slave bus
);
  localparam int NSEG = WIDTH/2 + 1;
  localparam int ITER = (NSEG + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
  localparam int YW   = 2*ITER*PP_PER_CYCLE;
  localparam int PW   = 2*WIDTH;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   x_q, x_d;       // multiplicand, pre-shifted by consumed segments
  logic [YW-1:0]   y_q, y_d;       // unconsumed multiplier bits, LSB = next segment
  logic            ylsb_q, ylsb_d; // overlap bit Y[2j-1] of the next segment
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept;
  logic            last;
  logic [YW:0]     ye;
  logic [2:0]      seg;
  logic [PW-1:0]   mag;
  logic            neg;
  logic [PW-1:0]   pp_sum;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = BUSY;
      BUSY: if (last) state_d = DONE;
      DONE: if (bus.out_ready) state_d = bus.in_valid ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready    = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    bus.out_valid   = (state_q == DONE);
    bus.out_product = prod_q;
  end

  assign accept = bus.in_valid && bus.in_ready;

  // Booth partial products for this cycle's segments
  always_comb begin
    ye     = {y_q, ylsb_q};
    pp_sum = '0;
    seg    = 3'b000;
    mag    = '0;
    neg    = 1'b0;
    for (int i = 0; i < PP_PER_CYCLE; i++) begin
      seg = ye[2*i+2 -: 3];
      mag = '0;
      neg = 1'b0;
      case (seg)
        3'b001, 3'b010: mag = x_q;
        3'b011:         mag = x_q << 1;
        3'b100: begin   mag = x_q << 1; neg = 1'b1; end
        3'b101, 3'b110: begin mag = x_q; neg = 1'b1; end
        default: ;
      endcase
      // negation as inverted magnitude plus a one at the segment's LSB weight
      if (neg) pp_sum = pp_sum + ((~mag) << (2*i)) + (PW'(1) << (2*i));
      else     pp_sum = pp_sum + (mag << (2*i));
    end
  end

  always_comb begin
    last = (cnt_q == CW'(ITER-1));
`ifdef BOOTH_EARLY_TERM_EN
    begin
      logic [YW-1:0] rem;
      // remaining bits (overlap bit included) all equal -> remaining segments are zero
      rem  = YW'($signed(y_q) >>> (2*PP_PER_CYCLE-1));
      last = last || (rem == '0) || (&rem);
    end
`endif
  end

  // Datapath next values
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    ylsb_d = ylsb_q;
    acc_d  = acc_q;
    prod_d = prod_q;
    cnt_d  = cnt_q;
    if (accept) begin
      x_d    = {{WIDTH{bus.in_signed & bus.in_a[WIDTH-1]}}, bus.in_a};
      y_d    = {{(YW-WIDTH){bus.in_signed & bus.in_b[WIDTH-1]}}, bus.in_b};
      ylsb_d = 1'b0;
      acc_d  = '0;
      cnt_d  = '0;
    end else if (state_q == BUSY) begin
      x_d    = x_q << (2*PP_PER_CYCLE);
      y_d    = YW'($signed(y_q) >>> (2*PP_PER_CYCLE));
      ylsb_d = y_q[2*PP_PER_CYCLE-1];
      acc_d  = acc_q + pp_sum;
      cnt_d  = cnt_q + CW'(1);
      if (last) prod_d = acc_q + pp_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      ylsb_q <= 1'b0;
      acc_q  <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      ylsb_q <= ylsb_d;
      acc_q  <= acc_d;
      prod_q <= prod_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule
